// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//
// Shares a single spi_master among NUM_REQ requesters. A requester holds req
// high for the whole burst; the arbiter grants bursts round-robin and frames
// each one with the owner's chip select. The owner's SPI mode and clock divider
// are latched at grant time and stay frozen for the burst. Each byte is handed
// to the master with a start pulse, and the received byte is routed back to the
// owner. A watchdog aborts a transfer whose rx_valid never arrives.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   CS_SETUP  cycles cs_n is low before the first start of a burst (>=1)
//   CS_HOLD   cycles cs_n stays low after the last rx_valid (>=1)
//   TIMEOUT   cycles allowed from m_start to m_rx_valid before abort
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req/req_data/...    per-requester byte request, tx byte, last flag, mode
//                       (cpol/cpha) and divider code
//   req_ack             1-cycle pulse: byte accepted, present the next one
//   rsp_valid/rsp_data  1-cycle pulse per owner with the shared rx byte
//   err                 1-cycle pulse: owner's burst aborted by the watchdog
//   cs_n                active-low chip selects, at most one low at a time
//   m_*                 start/config/tx out to spi_master, rx/busy back in
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ-1:0]     req_cpol,
  input  logic [NUM_REQ-1:0]     req_cpha,
  input  logic [2*NUM_REQ-1:0]   req_clk_div,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_data,
  output logic [NUM_REQ-1:0]     err,
  output logic [NUM_REQ-1:0]     cs_n,
  output logic                   m_start,
  output logic                   m_cpol,
  output logic                   m_cpha,
  output logic [1:0]             m_clk_div,
  output logic [7:0]             m_tx_data,
  input  logic [7:0]             m_rx_data,
  input  logic                   m_rx_valid,
  input  logic                   m_busy
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               m_start_q, m_start_d;
  logic               m_cpol_q, m_cpol_d;
  logic               m_cpha_q, m_cpha_d;
  logic [1:0]         m_clk_div_q, m_clk_div_d;
  logic [7:0]         m_tx_data_q, m_tx_data_d;

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] owner_oh;

  assign owner_oh = NUM_REQ'(1) << owner_q;

  // Round-robin search: first requester with req high starting just after
  // the last owner, wrapping around. The last owner itself is checked last.
  always_comb begin : arb_search
    logic [IDX_W:0] cand;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (!gnt_found && req[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wdog_d      = wdog_q;
    last_d      = last_q;
    cs_n_d      = cs_n_q;
    req_ack_d   = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = '0;
    m_start_d   = 1'b0;
    m_cpol_d    = m_cpol_q;
    m_cpha_d    = m_cpha_q;
    m_clk_div_d = m_clk_div_q;
    m_tx_data_d = m_tx_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          owner_d     = gnt_idx;
          // Mode and divider are frozen here for the whole burst, so SCLK
          // idle level settles during SETUP before the first edge.
          m_cpol_d    = req_cpol[gnt_idx];
          m_cpha_d    = req_cpha[gnt_idx];
          m_clk_div_d = req_clk_div[2*gnt_idx +: 2];
          cs_n_d      = ~(NUM_REQ'(1) << gnt_idx);
          cnt_d       = '0;
          state_d     = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ISSUE: begin
        if (!req[owner_q]) begin
          // Owner withdrew mid-burst: close the frame without another byte.
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (!m_busy) begin
          m_start_d   = 1'b1;
          req_ack_d   = owner_oh;
          m_tx_data_d = req_data[8*owner_q +: 8];
          last_d      = req_last[owner_q];
          wdog_d      = '0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (m_rx_valid) begin
          rsp_data_d  = m_rx_data;
          rsp_valid_d = owner_oh;
          cnt_d       = '0;
          state_d     = last_q ? S_HOLD : S_ISSUE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          // wdog_q counts cycles since m_start became visible, so err lands
          // exactly TIMEOUT cycles after the start pulse.
          err_d   = owner_oh;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cs_n_d  = '1;
          ptr_d   = owner_q;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        // One cycle with every cs_n high before the next grant.
        state_d = S_IDLE;
      end

      default: begin
        cs_n_d  = '1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      wdog_q      <= '0;
      last_q      <= 1'b0;
      cs_n_q      <= '1;
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= '0;
      m_start_q   <= 1'b0;
      m_cpol_q    <= 1'b0;
      m_cpha_q    <= 1'b0;
      m_clk_div_q <= 2'b01;
      m_tx_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      last_q      <= last_d;
      cs_n_q      <= cs_n_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      m_start_q   <= m_start_d;
      m_cpol_q    <= m_cpol_d;
      m_cpha_q    <= m_cpha_d;
      m_clk_div_q <= m_clk_div_d;
      m_tx_data_q <= m_tx_data_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign cs_n      = cs_n_q;
  assign m_start   = m_start_q;
  assign m_cpol    = m_cpol_q;
  assign m_cpha    = m_cpha_q;
  assign m_clk_div = m_clk_div_q;
  assign m_tx_data = m_tx_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
//
// Bench for spi_arbiter with a behavioural loopback spi_master. Each requester
// owns a byte queue ({last, data}); requester inputs follow the queue heads.
// When a byte is accepted, the expected rx byte (or an expected timeout error)
// is pushed to a scoreboard; a monitor pops and compares when the DUT responds.
// Expected grants (owner, byte count, mode, divider) are queued per scenario.
// -----------------------------------------------------------------------------
module tb_spi_arbiter;

  localparam int NR  = 4;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int TO  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req, req_last, req_cpol, req_cpha;
  logic [8*NR-1:0]   req_data;
  logic [2*NR-1:0]   req_clk_div;
  logic [NR-1:0]     req_ack, rsp_valid, err, cs_n;
  logic [7:0]        rsp_data, m_tx_data, m_rx_data;
  logic              m_start, m_cpol, m_cpha, m_rx_valid, m_busy;
  logic [1:0]        m_clk_div;

  always #5 clk = ~clk;

  spi_arbiter #(
    .NUM_REQ (NR),
    .CS_SETUP(CSS),
    .CS_HOLD (CSH),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_cpol   (req_cpol),
    .req_cpha   (req_cpha),
    .req_clk_div(req_clk_div),
    .req_ack    (req_ack),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .err        (err),
    .cs_n       (cs_n),
    .m_start    (m_start),
    .m_cpol     (m_cpol),
    .m_cpha     (m_cpha),
    .m_clk_div  (m_clk_div),
    .m_tx_data  (m_tx_data),
    .m_rx_data  (m_rx_data),
    .m_rx_valid (m_rx_valid),
    .m_busy     (m_busy)
  );

  typedef struct packed {
    logic [1:0] own;
    logic [3:0] nb;
    logic       cpol;
    logic       cpha;
    logic [1:0] div;
  } grant_t;

  logic [8:0] txq [NR][$];
  logic [9:0] exp_rsp [$];
  logic [1:0] exp_err [$];
  grant_t     exp_gnt [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int stub_total = 0;
  int stub_acked = 0;
  int stub_started = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [NR-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = NR - 1; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural spi_master: busy for 4+4*div cycles, then loops tx back as rx.
  // While stub_total is ahead of stub_started, a transfer is swallowed (busy
  // drops but rx_valid never rises).
  logic [4:0] mcnt;
  logic [7:0] mtx;
  logic       swallow;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy     <= 1'b0;
      m_rx_valid <= 1'b0;
      m_rx_data  <= 8'h00;
      mcnt       <= '0;
      mtx        <= 8'h00;
      swallow    <= 1'b0;
    end else begin
      m_rx_valid <= 1'b0;
      if (m_busy) begin
        if (mcnt == 5'd1) begin
          m_busy <= 1'b0;
          if (!swallow) begin
            m_rx_valid <= 1'b1;
            m_rx_data  <= mtx;
          end
        end else begin
          mcnt <= mcnt - 5'd1;
        end
      end else if (m_start) begin
        m_busy <= 1'b1;
        mcnt   <= 5'd4 + {1'b0, m_clk_div, 2'b00};
        mtx    <= m_tx_data;
        if (stub_total > stub_started) begin
          swallow      <= 1'b1;
          stub_started <= stub_started + 1;
        end else begin
          swallow <= 1'b0;
        end
      end
    end
  end

  // Requester driver: advance a queue on req_ack, push the expectation.
  initial begin
    req      = '0;
    req_last = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        logic [8:0] b;
        if (req_ack[i] && !reset) begin
          if (txq[i].size() == 0) begin
            chk("ack_unexp", 32'(req_ack[i]), 32'd0);
          end else begin
            b = txq[i].pop_front();
            if (stub_total > stub_acked) begin
              stub_acked++;
              exp_err.push_back(2'(i));
            end else begin
              exp_rsp.push_back({2'(i), b[7:0]});
            end
          end
        end
        req[i] = (txq[i].size() != 0);
        if (txq[i].size() != 0) begin
          req_data[8*i +: 8] = txq[i][0][7:0];
          req_last[i]        = txq[i][0][8];
        end
      end
    end
  end

  // Monitor: grants, framing, responses, errors, master handshake.
  initial begin
    logic [NR-1:0] prev_cs;
    logic [1:0]    oi;
    logic [9:0]    er;
    grant_t        cur;
    int            starts, start_cyc, last_rx, rise_cyc;
    bit            in_burst, aborted;
    prev_cs = '1; cur = '0; starts = 0; start_cyc = 0; last_rx = 0;
    rise_cyc = 0; in_burst = 0; aborted = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_burst = 0;
        prev_cs  = '1;
        rise_cyc = cyc;
      end else begin
        chk("cs_onehot", 32'($countones(~cs_n) <= 1), 32'd1);
        if (m_start) begin
          chk("start_busy", 32'(m_busy), 32'd0);
          starts++;
          start_cyc = cyc;
        end
        if (m_rx_valid) last_rx = cyc;
        if (rsp_valid != '0) begin
          oi = idx_of(rsp_valid);
          if (exp_rsp.size() == 0) begin
            chk("rsp_unexp", 32'(rsp_valid), 32'd0);
          end else begin
            er = exp_rsp.pop_front();
            chk("rsp_data", 32'({oi, rsp_data}), 32'(er));
            chk("rsp_lat", 32'(cyc - last_rx), 32'd1);
          end
        end
        if (err != '0) begin
          oi = idx_of(err);
          if (exp_err.size() == 0) begin
            chk("err_unexp", 32'(err), 32'd0);
          end else begin
            chk("err_owner", 32'(oi), 32'(exp_err.pop_front()));
          end
          chk("err_lat", 32'(cyc - start_cyc), 32'(TO));
          aborted = 1;
        end
        if (prev_cs == '1 && cs_n != '1) begin
          oi = idx_of(~cs_n);
          chk("gap", 32'((cyc - rise_cyc) >= 2), 32'd1);
          if (exp_gnt.size() == 0) begin
            chk("gnt_unexp", 32'(cs_n), 32'hF);
          end else begin
            cur = exp_gnt.pop_front();
            chk("gnt_owner", 32'(oi), 32'(cur.own));
            chk("gnt_cfg", 32'({m_cpol, m_cpha, m_clk_div}), 32'({cur.cpol, cur.cpha, cur.div}));
          end
          in_burst = 1; starts = 0; aborted = 0;
        end else if (prev_cs != '1 && cs_n != '1) begin
          chk("cs_steady", 32'(cs_n), 32'(prev_cs));
          chk("cfg_stable", 32'({m_cpol, m_cpha, m_clk_div}), 32'({cur.cpol, cur.cpha, cur.div}));
        end else if (prev_cs != '1 && cs_n == '1 && in_burst) begin
          chk("n_start", 32'(starts), 32'(cur.nb));
          if (!aborted) chk("hold_lat", 32'(cyc - last_rx), 32'(CSH + 1));
          rise_cyc = cyc;
          in_burst = 0;
        end
        prev_cs = cs_n;
      end
    end
  end

  task automatic set_cfg(input int i, input logic cpol, input logic cpha, input logic [1:0] div);
    req_cpol[i]          = cpol;
    req_cpha[i]          = cpha;
    req_clk_div[2*i +: 2] = div;
  endtask

  task automatic wait_idle(input int lim);
    int  n;
    bit  busy;
    n = 0;
    busy = 1;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
      busy = (exp_rsp.size() != 0) || (exp_err.size() != 0) ||
             (exp_gnt.size() != 0) || (cs_n != 4'hF);
      for (int i = 0; i < NR; i++) if (txq[i].size() != 0) busy = 1;
    end
    chk("idle_timeout", 32'(n < lim), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    req_cpol    = '0;
    req_cpha    = '0;
    req_clk_div = {NR{2'b01}};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_pulses", 32'({req_ack, rsp_valid, err, m_start}), 32'd0);
    chk("rst_data", 32'({rsp_data, m_tx_data}), 32'd0);
    chk("rst_cfg", 32'({m_cpol, m_cpha, m_clk_div}), 32'b0001);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin: all four requesters, two single-byte bursts each.
    for (int i = 0; i < NR; i++) begin
      set_cfg(i, 1'b0, 1'b0, 2'b01);
      txq[i].push_back({1'b1, 8'(8'h40 + i)});
      txq[i].push_back({1'b1, 8'(8'h50 + i)});
    end
    for (int k = 0; k < 2 * NR; k++) exp_gnt.push_back({2'(k % NR), 4'd1, 1'b0, 1'b0, 2'b01});
    wait_idle(3000);

    // Single byte from requester 1, mode 0.
    set_cfg(1, 1'b0, 1'b0, 2'b01);
    exp_gnt.push_back({2'd1, 4'd1, 1'b0, 1'b0, 2'b01});
    txq[1].push_back({1'b1, 8'hA5});
    wait_idle(1000);

    // Three-byte burst from requester 0, mode 3.
    set_cfg(0, 1'b1, 1'b1, 2'b00);
    exp_gnt.push_back({2'd0, 4'd3, 1'b1, 1'b1, 2'b00});
    txq[0].push_back({1'b0, 8'h11});
    txq[0].push_back({1'b0, 8'h22});
    txq[0].push_back({1'b1, 8'h33});
    wait_idle(1000);

    // Per-requester config switch: requester 2 then requester 3.
    set_cfg(2, 1'b1, 1'b0, 2'b11);
    set_cfg(3, 1'b0, 1'b0, 2'b00);
    exp_gnt.push_back({2'd2, 4'd1, 1'b1, 1'b0, 2'b11});
    exp_gnt.push_back({2'd3, 4'd1, 1'b0, 1'b0, 2'b00});
    txq[2].push_back({1'b1, 8'hF0});
    txq[3].push_back({1'b1, 8'hF0});
    wait_idle(1000);

    // Timeout on requester 1, then requester 2 served normally.
    stub_total = stub_total + 1;
    set_cfg(1, 1'b0, 1'b0, 2'b00);
    set_cfg(2, 1'b0, 1'b1, 2'b01);
    exp_gnt.push_back({2'd1, 4'd1, 1'b0, 1'b0, 2'b00});
    exp_gnt.push_back({2'd2, 4'd1, 1'b0, 1'b1, 2'b01});
    txq[1].push_back({1'b1, 8'h5C});
    txq[2].push_back({1'b1, 8'h3C});
    wait_idle(2000);

    // Reset during WAIT of a three-byte burst.
    set_cfg(0, 1'b0, 1'b0, 2'b01);
    exp_gnt.push_back({2'd0, 4'd3, 1'b0, 1'b0, 2'b01});
    txq[0].push_back({1'b0, 8'h81});
    txq[0].push_back({1'b0, 8'h82});
    txq[0].push_back({1'b1, 8'h83});
    n = 0;
    while (!m_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_wait", 32'(n < 200), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_cs_n", 32'(cs_n), 32'hF);
    chk("midrst_start", 32'(m_start), 32'd0);
    txq[0].delete();
    exp_rsp.delete();
    exp_err.delete();
    exp_gnt.delete();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_quiet", 32'({rsp_valid, err, req_ack}), 32'd0);
    end
    reset = 1'b0;

    // Normal operation after reset: pointer restarts at NUM_REQ-1.
    exp_gnt.push_back({2'd3, 4'd1, 1'b0, 1'b0, 2'b00});
    txq[3].push_back({1'b1, 8'h7E});
    wait_idle(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
